// File: rtl/sort_pkg.sv
// Shared definitions for the sort unloader: FSM encoding, default geometry
// and the index-width helper.
package sort_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 3;
  localparam int N_DEF     = 64;

  // Width needed to address 2*half elements; never narrower than one bit.
  function automatic int idx_w(input int half);
    return (half > 1) ? $clog2(2 * half) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(N_DEF);

endpackage

// File: rtl/sort_unloader_cmp.sv
// Unsigned less-than comparator used by the ordering check.
// Only compiled into the build when SORT_CHECK_EN is defined.
`ifdef SORT_CHECK_EN
module sort_unloader_cmp #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             lt_o
);

  assign lt_o = (a_i < b_i);

endmodule
`endif

// File: rtl/sort_unloader.sv
// Captures a sorted 2*n element bus and streams it out one element per
// valid/ready transfer. Optional SORT_CHECK_EN adds a sticky order_err output.
module sort_unloader
  import sort_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int n     = N_DEF,
  localparam int IW    = idx_w(n)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*n*WIDTH-1:0]  c_in,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  done
`ifdef SORT_CHECK_EN
  ,
  output logic                  order_err
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(2 * n - 1);

  state_e                       state_q;
  logic [IW-1:0]                idx_q;
  logic [2*n-1:0][WIDTH-1:0]    shadow_q;
  logic                         capture;
  logic                         xfer;

  assign capture   = (state_q == S_IDLE) && start;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_STREAM);
  assign done      = (state_q == S_DONE);
  assign out_idx   = idx_q;
  assign out_data  = shadow_q[idx_q];
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shadow_q <= c_in;
            idx_q    <= '0;
            state_q  <= S_STREAM;
          end
        end
        S_STREAM: begin
          // The final transfer leaves the index parked at the last element.
          if (out_ready) begin
            if (idx_q == LAST_IDX) state_q <= S_DONE;
            else                   idx_q   <= idx_q + IW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SORT_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q;
  logic             err_q;
  logic             lt;

  sort_unloader_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a_i  (out_data),
    .b_i  (prev_q),
    .lt_o (lt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (capture) begin
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (xfer) begin
      prev_q      <= out_data;
      have_prev_q <= 1'b1;
      if (have_prev_q && lt) err_q <= 1'b1;
    end
  end

  assign order_err = err_q;
`endif

endmodule

// File: tb/tb_sort_unloader.sv
// Directed bench for sort_unloader: streaming, backpressure, capture isolation,
// start-in-DONE handling, mid-stream reset and (with SORT_CHECK_EN) order check.
module tb_sort_unloader;

  localparam int WIDTH = 3;
  localparam int N     = 64;
  localparam int E     = 2 * N;
  localparam int IW    = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [E*WIDTH-1:0]   c_in;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic                 done;
`ifdef SORT_CHECK_EN
  logic                 order_err;
`endif

  sort_unloader #(.WIDTH(WIDTH), .n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_in      (c_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
`ifdef SORT_CHECK_EN
    ,
    .order_err (order_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_idx;
  logic [WIDTH-1:0] exp_mem [E];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] pat(input int mode, input int k);
    case (mode)
      0:       pat = WIDTH'(k % 8);
      1:       pat = WIDTH'((k * 3) % 8);
      2:       pat = WIDTH'(7);
      3:       pat = WIDTH'((k + 5) % 8);
      4:       pat = WIDTH'(k / 16);
      default: pat = (k == 0) ? WIDTH'(3) : (k == 1) ? WIDTH'(5) : (k == 2) ? WIDTH'(2) : WIDTH'(7);
    endcase
  endfunction

  task automatic set_cin(input int mode);
    for (int k = 0; k < E; k++) c_in[k*WIDTH +: WIDTH] = pat(mode, k);
  endtask

  task automatic snap();
    for (int k = 0; k < E; k++) exp_mem[k] = c_in[k*WIDTH +: WIDTH];
  endtask

  // Enter and leave at a falling edge; the frame is in STREAM on return.
  task automatic pulse_start();
    start = 1'b1;
    chk("pre_capture_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    exp_idx = 0;
  endtask

  // Check and transfer elements until exp_idx reaches stop; bp selects 1,0,0,1 ready.
  task automatic stream_to(input int stop, input bit bp);
    int c;
    c = 0;
    while (exp_idx < stop && c < 1000) begin
      out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_idx",   {25'd0, out_idx},   exp_idx);
      chk("stream_data",  {29'd0, out_data},  {29'd0, exp_mem[exp_idx]});
      chk("stream_last",  {31'd0, out_last},  {31'd0, exp_idx == E - 1});
      @(posedge clk);
      if (out_ready) exp_idx++;
      @(negedge clk);
      c++;
    end
    if (c >= 1000) chk("stream_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_done_then_idle();
    chk("done_pulse",  {31'd0, done},      32'd1);
    chk("done_valid",  {31'd0, out_valid}, 32'd0);
    chk("done_busy",   {31'd0, busy},      32'd1);
    @(negedge clk);
    chk("idle_done",   {31'd0, done},      32'd0);
    chk("idle_busy",   {31'd0, busy},      32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; c_in = '0;
    #2;
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {29'd0, out_data},  32'd0);
    chk("rst_idx",   {25'd0, out_idx},   32'd0);
    chk("rst_last",  {31'd0, out_last},  32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic streaming with out_ready held high.
    set_cin(0); snap();
    pulse_start();
    stream_to(E, 1'b0);
    chk_done_then_idle();

    // Backpressure with ready cycling 1,0,0,1.
    set_cin(1); snap();
    pulse_start();
    stream_to(E, 1'b1);
    chk_done_then_idle();

    // Capture isolation: new c_in and start mid-stream must not disturb the frame.
    set_cin(0); snap();
    pulse_start();
    stream_to(10, 1'b0);
    set_cin(2);
    start = 1'b1;
    stream_to(20, 1'b0);
    start = 1'b0;
    stream_to(E - 1, 1'b0);
    // Start held through the last transfer and DONE is only taken in IDLE.
    start = 1'b1;
    stream_to(E, 1'b0);
    chk("done_with_start", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("idle_after_done_busy",  {31'd0, busy},      32'd0);
    chk("idle_after_done_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    snap();
    exp_idx = 0;
    chk("recapture_valid", {31'd0, out_valid}, 32'd1);
    stream_to(40, 1'b0);
    chk("pre_reset_idx", {25'd0, out_idx}, 32'd40);

    // Asynchronous reset mid-stream.
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data",  {29'd0, out_data},  32'd0);
    chk("mid_rst_idx",   {25'd0, out_idx},   32'd0);
    chk("mid_rst_last",  {31'd0, out_last},  32'd0);
    chk("mid_rst_done",  {31'd0, done},      32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("no_resume_valid", {31'd0, out_valid}, 32'd0);
    set_cin(3); snap();
    pulse_start();
    stream_to(E, 1'b0);
    chk_done_then_idle();

`ifdef SORT_CHECK_EN
    // Out-of-order detection: 3,5,2 at indices 0..2.
    set_cin(5); snap();
    pulse_start();
    chk("oe_after_capture", {31'd0, order_err}, 32'd0);
    stream_to(1, 1'b0);
    chk("oe_idx0", {31'd0, order_err}, 32'd0);
    stream_to(2, 1'b0);
    chk("oe_idx1", {31'd0, order_err}, 32'd0);
    stream_to(3, 1'b0);
    chk("oe_idx2", {31'd0, order_err}, 32'd1);
    stream_to(E, 1'b0);
    chk("oe_sticky_done", {31'd0, order_err}, 32'd1);
    @(negedge clk);
    chk("oe_sticky_idle", {31'd0, order_err}, 32'd1);

    // Sorted frame keeps order_err low.
    set_cin(4); snap();
    pulse_start();
    chk("oe_cleared", {31'd0, order_err}, 32'd0);
    stream_to(E, 1'b0);
    chk("oe_sorted_done", {31'd0, order_err}, 32'd0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
